// File: rtl/cpu_bus_sched.sv
// Round-robin scheduler granting three CPU cores access to one shared device bus.
// Optional bus timeout enabled by defining ARB_TIMEOUT_EN.
module cpu_bus_sched #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int TMO = 63
) (
  input  logic            MCLK,
  input  logic            RST_N,
  input  logic [2:0]      REQ,
  input  logic [2:0]      REQ_WR,
  input  logic [3*AW-1:0] REQ_AD,
  input  logic [3*DW-1:0] REQ_DO,
  output logic [2:0]      ACK,
  output logic [DW-1:0]   RDATA,
  output logic [2:0]      GNT,
  output logic            ERR,
  output logic [AW-1:0]   DEV_AD,
  output logic            DEV_RD,
  output logic            DEV_WR,
  output logic [DW-1:0]   DEV_DI,
  input  logic            DEV_DV,
  input  logic [DW-1:0]   DEV_DO
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      own_q, own_d;
  logic [2:0]      gnt_q, gnt_d;
  logic [2:0]      ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-1:0]   dev_ad_q, dev_ad_d;
  logic            dev_rd_q, dev_rd_d;
  logic            dev_wr_q, dev_wr_d;
  logic [DW-1:0]   dev_di_q, dev_di_d;

  logic [1:0]      pick;
  logic            pick_vld;
  logic [1:0]      cand;
  logic            tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  assign tmo_hit = (state_q == BUSY) && !DEV_DV && (cnt_q == CW'(TMO - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order starts one past the last served core, so the last winner goes to the back.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    cand     = inc3(last_q);
    for (int i = 0; i < 3; i++) begin
      if (!pick_vld && REQ[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    dev_ad_d = dev_ad_q;
    dev_rd_d = dev_rd_q;
    dev_wr_d = dev_wr_q;
    dev_di_d = dev_di_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d    = 3'b000;
        ack_d    = 3'b000;
        err_d    = 1'b0;
        dev_rd_d = 1'b0;
        dev_wr_d = 1'b0;
        if (pick_vld) begin
          own_d    = pick;
          gnt_d    = 3'b001 << pick;
          dev_ad_d = REQ_AD[pick*AW +: AW];
          dev_di_d = REQ_DO[pick*DW +: DW];
          dev_wr_d = REQ_WR[pick];
          dev_rd_d = !REQ_WR[pick];
          state_d  = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      BUSY: begin
        if (DEV_DV || tmo_hit) begin
          if (!DEV_DV) begin
            rdata_d = '1;
          end else if (dev_rd_q) begin
            rdata_d = DEV_DO;
          end
          ack_d    = 3'b001 << own_q;
          err_d    = !DEV_DV;
          dev_rd_d = 1'b0;
          dev_wr_d = 1'b0;
          last_d   = own_q;
          state_d  = DONE;
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        ack_d   = 3'b000;
        gnt_d   = 3'b000;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= 2'd2;
      own_q    <= 2'd0;
      gnt_q    <= 3'b000;
      ack_q    <= 3'b000;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      dev_ad_q <= '0;
      dev_rd_q <= 1'b0;
      dev_wr_q <= 1'b0;
      dev_di_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      dev_ad_q <= dev_ad_d;
      dev_rd_q <= dev_rd_d;
      dev_wr_q <= dev_wr_d;
      dev_di_q <= dev_di_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign GNT    = gnt_q;
  assign ACK    = ack_q;
  assign ERR    = err_q;
  assign RDATA  = rdata_q;
  assign DEV_AD = dev_ad_q;
  assign DEV_RD = dev_rd_q;
  assign DEV_WR = dev_wr_q;
  assign DEV_DI = dev_di_q;

endmodule

// File: tb/tb_cpu_bus_sched.sv
// Testbench for cpu_bus_sched: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the scheduler.
module tb_cpu_bus_sched;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TB_TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            MCLK;
  logic            RST_N;
  logic [2:0]      REQ;
  logic [2:0]      REQ_WR;
  logic [3*AW-1:0] REQ_AD;
  logic [3*DW-1:0] REQ_DO;
  logic [2:0]      ACK;
  logic [DW-1:0]   RDATA;
  logic [2:0]      GNT;
  logic            ERR;
  logic [AW-1:0]   DEV_AD;
  logic            DEV_RD;
  logic            DEV_WR;
  logic [DW-1:0]   DEV_DI;
  logic            DEV_DV;
  logic [DW-1:0]   DEV_DO;

  cpu_bus_sched #(.AW(AW), .DW(DW), .TMO(TB_TMO)) dut (
    .MCLK(MCLK), .RST_N(RST_N), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_AD(REQ_AD),
    .REQ_DO(REQ_DO), .ACK(ACK), .RDATA(RDATA), .GNT(GNT), .ERR(ERR),
    .DEV_AD(DEV_AD), .DEV_RD(DEV_RD), .DEV_WR(DEV_WR), .DEV_DI(DEV_DI),
    .DEV_DV(DEV_DV), .DEV_DO(DEV_DO)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: who owns the bus, how long it has waited,
  // and whether the completion pulse is currently showing.
  int            m_last;
  int            m_owner;
  bit            m_ack_shown;
  int            m_wait;
  bit            m_is_write;
  logic [2:0]    exp_gnt, exp_ack;
  logic          exp_err, exp_rd, exp_wr;
  logic [DW-1:0] exp_rdata, exp_di;
  logic [AW-1:0] exp_ad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit timed;
    if (!RST_N) begin
      m_last = 2; m_owner = -1; m_ack_shown = 0; m_wait = 0; m_is_write = 0;
      exp_gnt = 0; exp_ack = 0; exp_err = 0; exp_rd = 0; exp_wr = 0;
      exp_rdata = 0; exp_di = 0; exp_ad = 0;
    end else if (m_ack_shown) begin
      m_ack_shown = 0;
      exp_ack = 0; exp_gnt = 0; exp_err = 0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= 3; i++) begin
        int c;
        c = (m_last + i) % 3;
        if (m_owner < 0 && REQ[c]) begin
          m_owner    = c;
          m_wait     = 0;
          m_is_write = REQ_WR[c];
          exp_gnt    = 3'(1 << c);
          exp_ad     = REQ_AD[c*AW +: AW];
          exp_di     = REQ_DO[c*DW +: DW];
          exp_wr     = REQ_WR[c];
          exp_rd     = !REQ_WR[c];
        end
      end
    end else begin
      timed = TMO_ON && !DEV_DV && (m_wait + 1 >= TB_TMO);
      if (DEV_DV || timed) begin
        if (timed) exp_rdata = '1;
        else if (!m_is_write) exp_rdata = DEV_DO;
        exp_ack = 3'(1 << m_owner);
        exp_err = timed;
        exp_rd = 0; exp_wr = 0;
        m_last = m_owner;
        m_owner = -1;
        m_ack_shown = 1;
      end else begin
        m_wait++;
      end
    end
  endtask

  task automatic checkOutput();
    check("gnt",    32'(GNT),    32'(exp_gnt));
    check("ack",    32'(ACK),    32'(exp_ack));
    check("err",    32'(ERR),    32'(exp_err));
    check("rdata",  32'(RDATA),  32'(exp_rdata));
    check("dev_ad", 32'(DEV_AD), 32'(exp_ad));
    check("dev_rd", 32'(DEV_RD), 32'(exp_rd));
    check("dev_wr", 32'(DEV_WR), 32'(exp_wr));
    check("dev_di", 32'(DEV_DI), 32'(exp_di));
  endtask

  // Inputs are set before calling; they stay put across the next posedge.
  task automatic tick();
    model_step();
    @(negedge MCLK);
    checkOutput();
  endtask

  task automatic settle();
    REQ = 0; DEV_DV = 0;
    tick(); tick(); tick();
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < 3; c++) begin
      if (exp_ack[c]) REQ[c] = ($urandom_range(0, 3) == 0);
      else if (!REQ[c]) REQ[c] = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 49) == 0) REQ[c] = 1'b0;
    end
    RST_N  = ($urandom_range(0, 299) != 0);
    REQ_WR = 3'($urandom);
    REQ_AD = {16'($urandom), 16'($urandom), 16'($urandom)};
    REQ_DO = 24'($urandom);
    DEV_DV = ($urandom_range(0, 2) == 0);
    DEV_DO = 8'($urandom);
  endtask

  initial begin
    int rd_cycles;
    int seen;
    int last_t;
    int busy_cycles;
    logic [2:0] order [6];
    order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    RST_N = 0; REQ = 3'b111; REQ_WR = 0; REQ_AD = 0; REQ_DO = 0; DEV_DV = 0; DEV_DO = 0;

    // Reset with all requests pending, then CPU0 must win first.
    tick(); tick();
    check("rst_gnt", 32'(GNT), 0);
    check("rst_ack", 32'(ACK), 0);
    check("rst_rd",  32'(DEV_RD), 0);
    check("rst_wr",  32'(DEV_WR), 0);
    RST_N = 1;
    tick();
    check("first_gnt", 32'(GNT), 32'h1);
    DEV_DV = 1;
    tick();
    settle();

    // CPU1 read with two wait states.
    REQ = 3'b010; REQ_WR = 0; REQ_AD = 48'h0000_6800_0000;
    tick();
    check("rd_ad", 32'(DEV_AD), 32'h6800);
    rd_cycles = 0;
    if (DEV_RD) rd_cycles++;
    tick(); if (DEV_RD) rd_cycles++;
    tick(); if (DEV_RD) rd_cycles++;
    DEV_DV = 1; DEV_DO = 8'h5A;
    tick(); if (DEV_RD) rd_cycles++;
    check("rd_strobe_len", 32'(rd_cycles), 3);
    check("rd_ack", 32'(ACK), 32'h2);
    check("rd_data", 32'(RDATA), 32'h5A);
    settle();

    // CPU2 write; read data register must keep its previous value.
    REQ = 3'b100; REQ_WR = 3'b100; REQ_AD = 48'h7100_0000_0000; REQ_DO = 24'hC3_0000;
    tick();
    check("wr_strobe", 32'(DEV_WR), 1);
    check("wr_rd_low", 32'(DEV_RD), 0);
    check("wr_di", 32'(DEV_DI), 32'hC3);
    check("wr_ad", 32'(DEV_AD), 32'h7100);
    DEV_DV = 1; DEV_DO = 8'h11;
    tick();
    check("wr_ack", 32'(ACK), 32'h4);
    check("wr_rdata_kept", 32'(RDATA), 32'h5A);
    settle();

    // All three requesting against a zero-wait device.
    REQ = 3'b111; REQ_WR = 0; DEV_DV = 1;
    seen = 0; last_t = 0;
    for (int t = 0; t < 40 && seen < 6; t++) begin
      tick();
      if (ACK != 0) begin
        check("fair_order", 32'(ACK), 32'(order[seen]));
        if (seen > 0) check("fair_spacing", 32'(t - last_t), 3);
        last_t = t;
        seen++;
      end
    end
    check("fair_count", 32'(seen), 6);
    settle();

    // Reset in the middle of a transaction.
    REQ = 3'b010; DEV_DV = 0;
    tick();
    check("abort_busy_gnt", 32'(GNT), 32'h2);
    RST_N = 0;
    tick();
    check("abort_gnt", 32'(GNT), 0);
    check("abort_ack", 32'(ACK), 0);
    check("abort_rd",  32'(DEV_RD), 0);
    check("abort_ad",  32'(DEV_AD), 0);
    RST_N = 1; REQ = 3'b011;
    tick();
    check("abort_regrant", 32'(GNT), 32'h1);
    REQ = 0; DEV_DV = 1;
    tick();
    settle();

    // Device that never answers.
    REQ = 3'b001; REQ_WR = 0; DEV_DV = 0;
    tick();
    busy_cycles = 1;
    for (int t = 0; t < 20 && ACK == 0; t++) begin
      tick();
      if (ACK == 0) busy_cycles++;
    end
`ifdef ARB_TIMEOUT_EN
    check("tmo_busy_len", 32'(busy_cycles), TB_TMO);
    check("tmo_ack", 32'(ACK), 32'h1);
    check("tmo_err", 32'(ERR), 1);
    check("tmo_rdata", 32'(RDATA), 32'hFF);
`else
    check("hang_gnt", 32'(GNT), 32'h1);
    check("hang_ack", 32'(ACK), 0);
    check("hang_err", 32'(ERR), 0);
    DEV_DV = 1;
    tick();
    check("hang_release_ack", 32'(ACK), 32'h1);
`endif
    REQ = 0;
    settle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
